pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard-detection and forwarding controller for the RV32 in-order pipeline. It generalises the fixed 5-stage hazard unit to a data memory of configurable latency (`MEM_LAT` stages), so the core can use multi-cycle RAM. The controller keeps an internal scoreboard of in-flight register writers and uses it to generate operand-forwarding selects, load-use stalls and branch flushes. It also keeps saturating stall and flush event counters for the debug/test-signal path. It sits in ID, beside the register file and the branch comparator.

## Interface
- `MEM_LAT`, 1: data-memory latency in stages (1..4). Scoreboard depth D = MEM_LAT+1.
- `CNT_W`, 16: width of the event counters.
- `FSEL_W`, $clog2(D+2): width of the forwarding selects.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `rs1_addr`, `rs2_addr` in 5 each: source registers of the ID instruction.
- `rs1_use`, `rs2_use` in 1 each: the ID instruction reads the corresponding source (branches and stores included).
- `rd_addr` in 5: destination register of the ID instruction.
- `reg_write` in 1: the ID instruction writes `rd_addr`.
- `is_load` in 1: the ID instruction is a load.
- `branch_taken` in 1: a taken branch or jump was resolved in ID.
- `pc_en` out 1: PC register enable.
- `fd_en` out 1: IF/ID register enable.
- `fd_flush` out 1: squash IF/ID contents.
- `de_flush` out 1: insert a bubble into ID/EX.
- `fwd_sel_a`, `fwd_sel_b` out FSEL_W each: forwarding mux selects.
- `stall_cnt` out CNT_W: count of stall cycles.
- `flush_cnt` out CNT_W: count of taken-branch flushes.

## Operation
- **Stage numbering.** Scoreboard entry s (1..D) tracks the instruction in stage s: s=1 is EX, s≥2 is MEM stage s−1. Each entry holds {valid, rd, load}. Register writes in WB are write-through in the register file, so WB needs no forwarding.
- **Forwarding select encoding.** 0 = register file. s (1..D) = ALU result of stage s. D+1 = load data returned at the last MEM stage. With MEM_LAT=1 this reproduces the legacy encoding: 0 reg, 1 EX ALU, 2 MEM ALU, 3 MEM data.
- **Match.** A source matches entry s when the source is used, entry s is valid, rd≠0, and rd equals the source address. When several entries match, the youngest (lowest s) wins.
- **Select for a matched source:**
  - Non-load entry: sel = s.
  - Load entry at s=D: sel = D+1.
  - Load entry at s<D: load-use hazard; the select is don't-care and is driven 0.
- **stall.** Asserted when `id_valid` is 1 and any used source has a load-use hazard.
- **Outputs under stall:** `pc_en`=0, `fd_en`=0, `de_flush`=1, `fd_flush`=0. `branch_taken` is ignored during stall, because the comparator operands are not yet valid.
- **Outputs for a taken branch without stall:** `fd_flush`=1, `pc_en`=1, `fd_en`=1, `de_flush`=0.
- **Otherwise:** `pc_en`=1, `fd_en`=1, both flushes 0.
- **Scoreboard shift, every cycle:**
  - entry[s] ← entry[s−1] for s=2..D.
  - entry[1] ← {1, rd_addr, is_load} when `id_valid` & !stall & `reg_write` & rd_addr≠0; otherwise entry[1] ← invalid.
  - The downstream pipeline never stalls.
- **Counters.** `stall_cnt` increments on every stall cycle. `flush_cnt` increments on every cycle with `fd_flush`=1. Both saturate at 2^CNT_W−1.

## Timing
- Forwarding selects, `stall`, enables and flushes are combinational from the current inputs and the registered scoreboard, with zero latency.
- A dependent instruction immediately after a load stalls exactly MEM_LAT cycles, then sees sel=D+1.
- An instruction two slots behind a load stalls MEM_LAT−1 cycles.
- An ALU producer never causes a stall.
- Reset (`rst`=1 at an edge): all scoreboard entries invalid and both counters 0 from the next cycle. While the cleared scoreboard is in effect, outputs are `pc_en`=1, `fd_en`=1, flushes 0, selects 0.
- Reset asserted mid-stall drops the stall in the following cycle.
- Simultaneous stall and `branch_taken`: stall wins, `flush_cnt` is unchanged, and the branch is re-evaluated once the stall releases.
- `id_valid`=0: no stall and no scoreboard insert. Selects are still computed but are don't-care.

## Structure
- Package `hazard_pkg` holds:
  - `sb_entry_t` {valid, rd[4:0], load}.
  - The FSEL encoding constants `FSEL_REG`=0 and the function `FSEL_LOADDATA(D)`=D+1.
  - The `MEM_LAT` legal-range check.
- Sub-module `hazard_scoreboard` holds the D-entry shift register, the reset logic and the youngest-match priority encoder. It is instantiated once and exposes per-source {hit, s, load}.
- The top level holds the stall/flush decode and the counters.

## Test plan
All scenarios use MEM_LAT=2, so D=3.
- **Load-use:** `lw x5` then `add x6,x5,x1` → stall for 2 cycles (`pc_en`=0, `de_flush`=1, `stall_cnt`=2), then `fwd_sel_a`=4 with no stall.
- **Back-to-back ALU:** `addi x7` then `sub x8,x7,x7` → `fwd_sel_a`=`fwd_sel_b`=1, no stall. The same consumer one slot later → sel=2; two slots later → sel=3.
- **Youngest-match priority:** `addi x3`, `addi x3`, then `or x4,x3` → sel=1, not 2.
- **x0 and unused sources:** producer writes x0, or `rs2_use`=0 with a matching address → sel=0, no stall, no scoreboard insert.
- **Branch:** `branch_taken`=1 with no hazard → `fd_flush`=1 and `flush_cnt` increments by 1. `branch_taken`=1 during a load-use stall → `fd_flush`=0 and `flush_cnt` is unchanged.
- **Reset:** `rst` asserted during the first stall cycle → next cycle `pc_en`=1, scoreboard empty, `stall_cnt`=`flush_cnt`=0. Also force `stall_cnt` to 2^CNT_W−1 → it holds at that value.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } sb_entry_t;

  localparam int unsigned FSEL_REG = 0;
  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  // Select code for load data returned at the last MEM stage of a depth-d scoreboard.
  function automatic int unsigned FSEL_LOADDATA(input int unsigned d);
    return d + 1;
  endfunction

  function automatic bit mem_lat_ok(input int unsigned mem_lat);
    return (mem_lat >= MEM_LAT_MIN) && (mem_lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage operand/destination info in, pipeline control and debug counters out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned FSEL_W = 2,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic              rs1_use;
  logic              rs2_use;
  logic [4:0]        rd_addr;
  logic              reg_write;
  logic              is_load;
  logic              branch_taken;
  logic              pc_en;
  logic              fd_en;
  logic              fd_flush;
  logic              de_flush;
  logic [FSEL_W-1:0] fwd_sel_a;
  logic [FSEL_W-1:0] fwd_sel_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, rs1_addr, rs2_addr, rs1_use, rs2_use, rd_addr, reg_write, is_load,
           branch_taken,
    input  pc_en, fd_en, fd_flush, de_flush, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, rs1_addr, rs2_addr, rs1_use, rs2_use, rd_addr, reg_write, is_load,
           branch_taken,
    output pc_en, fd_en, fd_flush, de_flush, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight register writers (EX, MEM1..MEMn) with a
// youngest-first match lookup for the two ID source operands.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned D       = MEM_LAT + 1,
  parameter int unsigned SW      = $clog2(D + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0][4:0]      src_addr,
  input  logic [1:0]           src_use,
  input  sb_entry_t            ins,
  output logic [1:0]           hit,
  output logic [1:0][SW-1:0]   stage,
  output logic [1:0]           load
);

  sb_entry_t sb [1:D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= int'(D); s++) sb[s] <= '0;
    end else begin
      sb[1] <= ins;
      for (int s = 2; s <= int'(D); s++) sb[s] <= sb[s-1];
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit   = '0;
    stage = '0;
    load  = '0;
    for (int i = 0; i < 2; i++) begin
      for (int s = int'(D); s >= 1; s--) begin
        if (src_use[i] && sb[s].valid && (sb[s].rd != 5'd0) && (sb[s].rd == src_addr[i])) begin
          hit[i]   = 1'b1;
          stage[i] = SW'(s);
          load[i]  = sb[s].load;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch flush and operand-forwarding control for the ID stage,
// with saturating stall/flush event counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned FSEL_W  = $clog2(MEM_LAT + 3)
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned D  = MEM_LAT + 1;
  localparam int unsigned SW = $clog2(D + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
    $error("pipe_hazard_ctrl: MEM_LAT must be in 1..4");
  end

  logic [1:0][4:0]        src_addr;
  logic [1:0]             src_use;
  logic [1:0]             hit;
  logic [1:0][SW-1:0]     stage;
  logic [1:0]             load;
  logic [1:0]             lu_hazard;
  logic [1:0][FSEL_W-1:0] sel;
  logic                   stall_c;
  logic                   flush_c;
  sb_entry_t              ins;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       flush_cnt;

  assign src_addr = {bus.rs2_addr, bus.rs1_addr};
  assign src_use  = {bus.rs2_use, bus.rs1_use};

  hazard_scoreboard #(
    .MEM_LAT (MEM_LAT),
    .D       (D),
    .SW      (SW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .src_addr (src_addr),
    .src_use  (src_use),
    .ins      (ins),
    .hit      (hit),
    .stage    (stage),
    .load     (load)
  );

  // A load still short of the last MEM stage cannot be forwarded yet.
  always_comb begin
    lu_hazard = '0;
    ins       = '0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = FSEL_W'(FSEL_REG);
      if (hit[i]) begin
        if (!load[i])                 sel[i] = FSEL_W'(stage[i]);
        else if (stage[i] == SW'(D))  sel[i] = FSEL_W'(FSEL_LOADDATA(D));
        else                          lu_hazard[i] = 1'b1;
      end
    end
    stall_c = bus.id_valid && (lu_hazard != 2'b00);
    flush_c = bus.branch_taken && !stall_c;
    if (bus.id_valid && !stall_c && bus.reg_write && (bus.rd_addr != 5'd0)) begin
      ins.valid = 1'b1;
      ins.rd    = bus.rd_addr;
      ins.load  = bus.is_load;
    end
    bus.pc_en     = !stall_c;
    bus.fd_en     = !stall_c;
    bus.de_flush  = stall_c;
    bus.fd_flush  = flush_c;
    bus.fwd_sel_a = sel[0];
    bus.fwd_sel_b = sel[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_c && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl at MEM_LAT=2 (D=3, load-data select 4), 4-bit counters.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FSEL_W  = 3;

  localparam logic [3:0] RUN   = 4'b1100;  // {pc_en, fd_en, fd_flush, de_flush}
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] BR    = 4'b1110;

  logic clk;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  pipe_hazard_ctrl_if #(.FSEL_W(FSEL_W), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .MEM_LAT (MEM_LAT),
    .CNT_W   (CNT_W),
    .FSEL_W  (FSEL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ctl();
    return {bus.pc_en, bus.fd_en, bus.fd_flush, bus.de_flush};
  endfunction

  // One ID cycle: inputs change at negedge, outputs settle 1 time unit later.
  task automatic drive(input logic v, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic br);
    @(negedge clk);
    bus.id_valid = v;  bus.rs1_addr = a;  bus.rs1_use = ua;
    bus.rs2_addr = b;  bus.rs2_use = ub;  bus.rd_addr = rd;
    bus.reg_write = rw; bus.is_load = ld; bus.branch_taken = br;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rd);
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    drive(1'b1, a, 1'b1, b, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    total_cnt++; if (ctl() !== RUN) $display("FAIL reset_ctl got %b exp %b", ctl(), RUN); else pass_cnt++;
    total_cnt++; if (bus.fwd_sel_a !== 3'd0 || bus.fwd_sel_b !== 3'd0) $display("FAIL reset_sel got %0d/%0d exp 0/0", bus.fwd_sel_a, bus.fwd_sel_b); else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); else pass_cnt++;
    rst = 1'b0;
    idle(1);
    total_cnt++; if (ctl() !== RUN) $display("FAIL reset_release_ctl got %b exp %b", ctl(), RUN); else pass_cnt++;
  endtask

  task automatic test_load_use();
    lw(5'd5);
    total_cnt++; if (ctl() !== RUN) $display("FAIL lu_load_ctl got %b exp %b", ctl(), RUN); else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      alu(5'd6, 5'd5, 5'd1);
      total_cnt++; if (ctl() !== STALL) $display("FAIL lu_stall%0d_ctl got %b exp %b", c, ctl(), STALL); else pass_cnt++;
    end
    alu(5'd6, 5'd5, 5'd1);
    total_cnt++; if (ctl() !== RUN) $display("FAIL lu_release_ctl got %b exp %b", ctl(), RUN); else pass_cnt++;
    total_cnt++; if (bus.fwd_sel_a !== 3'd4 || bus.fwd_sel_b !== 3'd0) $display("FAIL lu_release_sel got %0d/%0d exp 4/0", bus.fwd_sel_a, bus.fwd_sel_b); else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 4'd2) $display("FAIL lu_stall_cnt got %0d exp 2", bus.stall_cnt); else pass_cnt++;
    // Consumer two slots behind the load stalls one cycle.
    idle(3);
    lw(5'd9);
    idle(1);
    alu(5'd10, 5'd9, 5'd0);
    total_cnt++; if (ctl() !== STALL) $display("FAIL lu2_stall_ctl got %b exp %b", ctl(), STALL); else pass_cnt++;
    alu(5'd10, 5'd9, 5'd0);
    total_cnt++; if (ctl() !== RUN || bus.fwd_sel_a !== 3'd4) $display("FAIL lu2_release got ctl %b sel %0d exp %b sel 4", ctl(), bus.fwd_sel_a, RUN); else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 4'd3) $display("FAIL lu2_stall_cnt got %0d exp 3", bus.stall_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int gap = 0; gap < 4; gap++) begin
      idle(3);
      alu(5'd7, 5'd2, 5'd0);
      idle(gap);
      alu(5'd8, 5'd7, 5'd7);
      total_cnt++;
      if (ctl() !== RUN || bus.fwd_sel_a !== 3'(gap == 3 ? 0 : gap + 1) || bus.fwd_sel_b !== 3'(gap == 3 ? 0 : gap + 1))
        $display("FAIL b2b_gap%0d got ctl %b sel %0d/%0d exp ctl %b sel %0d", gap, ctl(), bus.fwd_sel_a, bus.fwd_sel_b, RUN, (gap == 3 ? 0 : gap + 1));
      else pass_cnt++;
    end
  endtask

  task automatic test_priority();
    idle(3);
    alu(5'd3, 5'd2, 5'd0);
    alu(5'd3, 5'd2, 5'd0);
    alu(5'd4, 5'd3, 5'd3);
    total_cnt++; if (bus.fwd_sel_a !== 3'd1 || bus.fwd_sel_b !== 3'd1) $display("FAIL prio_alu got %0d/%0d exp 1/1", bus.fwd_sel_a, bus.fwd_sel_b); else pass_cnt++;
    // Younger ALU writer shadows an older in-flight load: no stall.
    idle(3);
    lw(5'd11);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    alu(5'd12, 5'd11, 5'd0);
    total_cnt++; if (ctl() !== RUN || bus.fwd_sel_a !== 3'd1) $display("FAIL prio_shadow got ctl %b sel %0d exp %b sel 1", ctl(), bus.fwd_sel_a, RUN); else pass_cnt++;
  endtask

  task automatic test_x0_unused();
    idle(3);
    alu(5'd0, 5'd2, 5'd0);
    alu(5'd4, 5'd0, 5'd0);
    total_cnt++; if (ctl() !== RUN || bus.fwd_sel_a !== 3'd0 || bus.fwd_sel_b !== 3'd0) $display("FAIL x0_alu got ctl %b sel %0d/%0d exp %b 0/0", ctl(), bus.fwd_sel_a, bus.fwd_sel_b, RUN); else pass_cnt++;
    idle(3);
    lw(5'd0);
    alu(5'd4, 5'd0, 5'd0);
    total_cnt++; if (ctl() !== RUN) $display("FAIL x0_load_ctl got %b exp %b", ctl(), RUN); else pass_cnt++;
    idle(3);
    lw(5'd12);
    drive(1'b1, 5'd1, 1'b1, 5'd12, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (ctl() !== RUN || bus.fwd_sel_b !== 3'd0) $display("FAIL unused_src got ctl %b sel_b %0d exp %b 0", ctl(), bus.fwd_sel_b, RUN); else pass_cnt++;
    idle(3);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0);
    alu(5'd4, 5'd13, 5'd13);
    total_cnt++; if (ctl() !== RUN || bus.fwd_sel_a !== 3'd0) $display("FAIL invalid_insert got ctl %b sel %0d exp %b 0", ctl(), bus.fwd_sel_a, RUN); else pass_cnt++;
  endtask

  task automatic test_branch();
    idle(3);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    total_cnt++; if (ctl() !== BR) $display("FAIL br_ctl got %b exp %b", ctl(), BR); else pass_cnt++;
    idle(1);
    total_cnt++; if (bus.flush_cnt !== 4'd1) $display("FAIL br_flush_cnt got %0d exp 1", bus.flush_cnt); else pass_cnt++;
    lw(5'd14);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      total_cnt++; if (ctl() !== STALL) $display("FAIL br_stall%0d_ctl got %b exp %b", c, ctl(), STALL); else pass_cnt++;
    end
    total_cnt++; if (bus.flush_cnt !== 4'd1) $display("FAIL br_stall_flush_cnt got %0d exp 1", bus.flush_cnt); else pass_cnt++;
    drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    total_cnt++; if (ctl() !== BR || bus.fwd_sel_a !== 3'd4) $display("FAIL br_reeval got ctl %b sel %0d exp %b sel 4", ctl(), bus.fwd_sel_a, BR); else pass_cnt++;
    idle(1);
    total_cnt++; if (bus.flush_cnt !== 4'd2 || bus.stall_cnt !== 4'd5) $display("FAIL br_cnts got %0d/%0d exp 2/5", bus.flush_cnt, bus.stall_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    lw(5'd15);
    alu(5'd16, 5'd15, 5'd0);
    rst = 1'b1;
    total_cnt++; if (ctl() !== STALL) $display("FAIL rstmid_stall_ctl got %b exp %b", ctl(), STALL); else pass_cnt++;
    alu(5'd16, 5'd15, 5'd0);
    rst = 1'b0;
    total_cnt++; if (ctl() !== RUN || bus.fwd_sel_a !== 3'd0) $display("FAIL rstmid_release got ctl %b sel %0d exp %b sel 0", ctl(), bus.fwd_sel_a, RUN); else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); else pass_cnt++;
  endtask

  task automatic lu_pair();
    lw(5'd5);
    for (int c = 0; c < 3; c++) alu(5'd6, 5'd5, 5'd0);
  endtask

  task automatic test_saturation();
    idle(3);
    for (int k = 0; k < 7; k++) lu_pair();
    idle(1);
    total_cnt++; if (bus.stall_cnt !== 4'd14) $display("FAIL sat_pre got %0d exp 14", bus.stall_cnt); else pass_cnt++;
    lu_pair();
    idle(1);
    total_cnt++; if (bus.stall_cnt !== 4'd15) $display("FAIL sat_hit got %0d exp 15", bus.stall_cnt); else pass_cnt++;
    lu_pair();
    idle(1);
    total_cnt++; if (bus.stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d exp 15", bus.stall_cnt); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.rs1_addr = '0; bus.rs1_use = 1'b0;
    bus.rs2_addr = '0;   bus.rs2_use = 1'b0; bus.rd_addr = '0;
    bus.reg_write = 1'b0; bus.is_load = 1'b0; bus.branch_taken = 1'b0;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_priority();
    test_x0_unused();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
